bzmusic_note_player: RTL and testbench
======================================

Name: bzmusic_note_player

Overview:
- Datapath responder to the buzzer-music sequencing controller.
- Consumes the controller's enable/reset strobes and answers with addr_finish / beat_finish.
- Owns the song address counter, the current-note register, the tone half-period generator and the beat-duration counter.
- Drives the buzzer pin directly and reads note words from an external asynchronous-read song ROM.

Parameters:
- ADDR_W, 8: song ROM address width. Each of the 4 songs owns a 2^(ADDR_W-2)-word region.
- CLK_HZ, 50_000_000: system clock frequency, used to derive tone half-periods.
- BEAT_TICKS, 12_500_000: clocks per beat unit (0.25 s at 50 MHz).
- GAP_TICKS, 1_250_000: articulation gap length (optional feature only). Must be < BEAT_TICKS.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- sel  in  2  song select; base address = sel << (ADDR_W-2).
- addr_en  in  1  fetch strobe: latch the current note and advance the address.
- addr_rstn  in  1  active-low clear of the address counter to the song base.
- tune_pwm_en  in  1  tone generator run enable.
- tune_pwm_rstn  in  1  active-low clear of the tone counter and buzzer.
- beat_cnt_en  in  1  beat counter run enable.
- beat_cnt_rstn  in  1  active-low clear of the beat counters.
- rom_addr  out  ADDR_W  song ROM address (registered address counter).
- rom_data  in  8  ROM word {note[7:3], beat[2:0]}, combinational on rom_addr.
- addr_finish  out  1  end-of-song indication.
- beat_finish  out  1  note-duration-complete pulse.
- buzzer  out  1  square-wave output to the passive buzzer.

Behaviour:
- Reset: rstn sampled low at a rising edge clears all state on that edge.
  - rom_addr=0, note_reg=0, beat_reg=0, tone_cnt=0, tick_cnt=0, beat_idx=0, buzzer=0.
  - addr_finish=0 and beat_finish=0 because the enables are low.
  - rstn has priority over every other input.
- Address counter:
  - addr_rstn=0: rom_addr <= {sel, zeros}. Same-cycle addr_en is ignored.
  - Else, if addr_en and rom_data[2:0]!=0: note_reg<=rom_data[7:3], beat_reg<=rom_data[2:0], rom_addr<=rom_addr+1.
  - The increment wraps within ADDR_W, and the top 2 bits may cross into the next song. Song authors must terminate every song.
- addr_finish: combinational, = addr_en & (rom_data[2:0]==0).
  - Beat field 0 is the end-of-song marker.
  - On the marker, note_reg, beat_reg and rom_addr hold. The controller returns to idle in the same cycle.
- Note table (note_reg code -> half-period = floor(CLK_HZ/(2*f))):
  - Codes 1..21 = natural notes C D E F G A B over octaves 4, 5, 6.
  - Code 1 = C4 262 Hz -> 95419. Code 6 = A4 440 Hz -> 56818. Code 21 = B6 1976 Hz -> 12651.
  - Codes 0 and 22..31 = rest.
  - Table is a case ROM of half-period constants computed at elaboration from CLK_HZ.
- Tone generator:
  - tune_pwm_rstn=0: tone_cnt<=0, buzzer<=0.
  - Else, if tune_pwm_en: tone_cnt increments. At half-period-1, tone_cnt wraps to 0 and buzzer toggles.
  - Rest code: buzzer forced 0, tone_cnt held 0.
  - tune_pwm_en=0 with reset inactive: tone_cnt and buzzer hold.
- Beat counter:
  - beat_cnt_rstn=0: tick_cnt<=0, beat_idx<=0.
  - Else, if beat_cnt_en: tick_cnt increments. At BEAT_TICKS-1, tick_cnt wraps to 0 and beat_idx increments.
- beat_finish: combinational, = beat_cnt_en & (tick_cnt==BEAT_TICKS-1) & (beat_idx==beat_reg-1).
  - Asserted for exactly one cycle per note. The note lasts beat_reg*BEAT_TICKS clocks of beat_cnt_en.
  - On that cycle the counters wrap to 0. The controller's fetch cycle then also clears them via beat_cnt_rstn.
- Simultaneous events:
  - A clear and an enable on the same block in the same cycle: the clear wins.
  - A song switch mid-note (controller pulls all resets low) silences the buzzer on the next edge. The address reloads to the new base.
- Counter widths: tick_cnt = $clog2(BEAT_TICKS), tone_cnt = 17 bits minimum, sized from the C4 half-period.

Optional Feature:
- Macro BZMUSIC_STACCATO_EN.
- Defined: during the final GAP_TICKS clocks of each note's last beat (beat_idx==beat_reg-1 and tick_cnt>=BEAT_TICKS-GAP_TICKS), buzzer is forced 0 and tone_cnt is held 0. Repeated identical notes are therefore audibly separated. beat_finish timing is unchanged.
- Undefined: notes play legato for their full duration.

Test Plan:
- Reset: rstn=0 for 2 cycles mid-tone -> buzzer=0, rom_addr=0, no finish pulses. Outputs stay idle until the enables are driven.
- Fetch: sel=2, addr_rstn=0 then addr_en=1 with rom_data=8'b00110_010 -> rom_addr goes 0x80 then 0x81, note_reg=6, beat_reg=2, addr_finish=0.
- Tone: note A4 (code 6), tune_pwm_en=1 -> buzzer toggles every 56818 clocks, period 113636 clocks. Code 0 -> buzzer held 0.
- Beat: BEAT_TICKS=10 override, beat_reg=3, beat_cnt_en=1 -> single beat_finish pulse on the 30th enabled cycle. None earlier.
- End of song: addr_en=1 with rom_data beat field 0 -> addr_finish=1 in the same cycle; rom_addr and note_reg unchanged.
- Staccato (macro defined, BEAT_TICKS=10, GAP_TICKS=3, beat_reg=1): buzzer forced 0 on enabled cycles 8..10. beat_finish still on cycle 10.

Source files
------------

// File: rtl/bzmusic_note_player_if.sv
// rtl/bzmusic_note_player_if.sv - controller strobes, finish flags and song ROM bus
interface bzmusic_note_player_if #(
  parameter int ADDR_W = 8
);
  logic [1:0]        sel;
  logic              addr_en;
  logic              addr_rstn;
  logic              tune_pwm_en;
  logic              tune_pwm_rstn;
  logic              beat_cnt_en;
  logic              beat_cnt_rstn;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              addr_finish;
  logic              beat_finish;

  // Controller and song ROM side
  modport master (
    output sel, addr_en, addr_rstn, tune_pwm_en, tune_pwm_rstn,
    output beat_cnt_en, beat_cnt_rstn, rom_data,
    input  rom_addr, addr_finish, beat_finish
  );

  // Note player side
  modport slave (
    input  sel, addr_en, addr_rstn, tune_pwm_en, tune_pwm_rstn,
    input  beat_cnt_en, beat_cnt_rstn, rom_data,
    output rom_addr, addr_finish, beat_finish
  );
endinterface

// File: rtl/bzmusic_note_player.sv
// rtl/bzmusic_note_player.sv - buzzer note player datapath; BZMUSIC_STACCATO_EN adds an articulation gap
module bzmusic_note_player #(
  parameter int ADDR_W     = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BEAT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input  logic                        clk,
  input  logic                        rstn,
  bzmusic_note_player_if.slave        bus,
  output logic                        buzzer
);

`ifdef BZMUSIC_STACCATO_EN
  localparam bit STACCATO = 1'b1;
`else
  localparam bit STACCATO = 1'b0;
`endif

  // C4 has the longest half-period, so it sizes the tone counter
  localparam int C4_HALF = CLK_HZ / (2 * 262);
  localparam int TONE_W  = ($clog2(C4_HALF + 1) > 17) ? $clog2(C4_HALF + 1) : 17;
  localparam int TICK_W  = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  function automatic logic [TONE_W-1:0] hp(input int freq);
    return TONE_W'(CLK_HZ / (2 * freq));
  endfunction

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        note_q, note_d;
  logic [2:0]        beat_q, beat_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              buzzer_q, buzzer_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        beat_idx_q, beat_idx_d;
  logic [TONE_W-1:0] half;
  logic              tick_wrap, last_beat, gap, beat_fin;

  assign tick_wrap = (tick_q == TICK_W'(BEAT_TICKS - 1));
  assign last_beat = (beat_idx_q == (beat_q - 3'd1));
  assign beat_fin  = bus.beat_cnt_en & tick_wrap & last_beat;
  assign gap       = STACCATO && last_beat && (tick_q >= TICK_W'(BEAT_TICKS - GAP_TICKS));

  assign bus.rom_addr    = addr_q;
  assign bus.addr_finish = bus.addr_en & (bus.rom_data[2:0] == 3'd0);
  assign bus.beat_finish = beat_fin;
  assign buzzer          = buzzer_q;

  // Note code to half-period lookup; zero marks a rest
  always_comb begin
    half = '0;
    case (note_q)
      5'd1:    half = hp(262);
      5'd2:    half = hp(294);
      5'd3:    half = hp(330);
      5'd4:    half = hp(349);
      5'd5:    half = hp(392);
      5'd6:    half = hp(440);
      5'd7:    half = hp(494);
      5'd8:    half = hp(523);
      5'd9:    half = hp(587);
      5'd10:   half = hp(659);
      5'd11:   half = hp(698);
      5'd12:   half = hp(784);
      5'd13:   half = hp(880);
      5'd14:   half = hp(988);
      5'd15:   half = hp(1046);
      5'd16:   half = hp(1175);
      5'd17:   half = hp(1318);
      5'd18:   half = hp(1397);
      5'd19:   half = hp(1568);
      5'd20:   half = hp(1760);
      5'd21:   half = hp(1976);
      default: half = '0;
    endcase
  end

  // Song address counter and current-note latch; the end marker holds everything
  always_comb begin
    addr_d = addr_q;
    note_d = note_q;
    beat_d = beat_q;
    if (!bus.addr_rstn) begin
      addr_d = {bus.sel, {(ADDR_W-2){1'b0}}};
    end else if (bus.addr_en && (bus.rom_data[2:0] != 3'd0)) begin
      note_d = bus.rom_data[7:3];
      beat_d = bus.rom_data[2:0];
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Tone half-period generator; rests and the staccato gap keep the pin low
  always_comb begin
    tone_d   = tone_q;
    buzzer_d = buzzer_q;
    if (!bus.tune_pwm_rstn) begin
      tone_d   = '0;
      buzzer_d = 1'b0;
    end else if (bus.tune_pwm_en) begin
      if ((half == '0) || gap) begin
        tone_d   = '0;
        buzzer_d = 1'b0;
      end else if (tone_q >= (half - TONE_W'(1))) begin
        tone_d   = '0;
        buzzer_d = ~buzzer_q;
      end else begin
        tone_d = tone_q + TONE_W'(1);
      end
    end
  end

  // Beat-duration counter; both counters restart when the note completes
  always_comb begin
    tick_d     = tick_q;
    beat_idx_d = beat_idx_q;
    if (!bus.beat_cnt_rstn) begin
      tick_d     = '0;
      beat_idx_d = '0;
    end else if (bus.beat_cnt_en) begin
      if (tick_wrap) begin
        tick_d     = '0;
        beat_idx_d = last_beat ? 3'd0 : (beat_idx_q + 3'd1);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q     <= '0;
      note_q     <= '0;
      beat_q     <= '0;
      tone_q     <= '0;
      buzzer_q   <= 1'b0;
      tick_q     <= '0;
      beat_idx_q <= '0;
    end else begin
      addr_q     <= addr_d;
      note_q     <= note_d;
      beat_q     <= beat_d;
      tone_q     <= tone_d;
      buzzer_q   <= buzzer_d;
      tick_q     <= tick_d;
      beat_idx_q <= beat_idx_d;
    end
  end

endmodule

// File: tb/tb_bzmusic_note_player.sv
// tb/tb_bzmusic_note_player.sv - scoreboard bench for bzmusic_note_player
module tb_bzmusic_note_player;
  localparam int ADDR_W = 8;
  localparam int CLK_HZ = 200_000;
  localparam int BT     = 10;
  localparam int GAP    = 3;
`ifdef BZMUSIC_STACCATO_EN
  localparam bit STACC = 1'b1;
`else
  localparam bit STACC = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       buz;
    logic       af;
    logic       bf;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic buzzer;
  logic [7:0] rom [256];
  exp_t exp_q [$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic obs_af, obs_bf;
  int freq_tab [22] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698,
                        784, 880, 988, 1046, 1175, 1318, 1397, 1568, 1760, 1976};

  // Reference model state: elapsed counts enabled clocks into the current note
  int m_addr, m_note, m_beat, m_ph, m_el;
  bit m_buz;

  bzmusic_note_player_if #(.ADDR_W(ADDR_W)) bus ();

  bzmusic_note_player #(
    .ADDR_W(ADDR_W), .CLK_HZ(CLK_HZ), .BEAT_TICKS(BT), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .buzzer(buzzer)
  );

  always #5 clk = ~clk;
  assign bus.rom_data = rom[bus.rom_addr];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic int half_of(int code);
    if (code >= 1 && code <= 21) return CLK_HZ / (2 * freq_tab[code]);
    return 0;
  endfunction

  function automatic bit m_last_beat();
    return ((m_el / BT) % 8) == ((m_beat + 7) % 8);
  endfunction

  function automatic bit m_bf();
    return bus.beat_cnt_en && ((m_el % BT) == BT - 1) && m_last_beat();
  endfunction

  task automatic model_reset();
    m_addr = 0; m_note = 0; m_beat = 0; m_ph = 0; m_el = 0; m_buz = 1'b0;
  endtask

  task automatic model_update();
    int rd, hlf;
    bit bf, gp;
    if (!rstn) begin
      model_reset();
      return;
    end
    rd  = int'(rom[m_addr]);
    bf  = m_bf();
    gp  = STACC && m_last_beat() && ((m_el % BT) >= BT - GAP);
    hlf = half_of(m_note);
    if (!bus.tune_pwm_rstn) begin
      m_ph = 0; m_buz = 1'b0;
    end else if (bus.tune_pwm_en) begin
      if (hlf == 0 || gp) begin
        m_ph = 0; m_buz = 1'b0;
      end else if (m_ph + 1 >= hlf) begin
        m_ph = 0; m_buz = !m_buz;
      end else begin
        m_ph++;
      end
    end
    if (!bus.beat_cnt_rstn) m_el = 0;
    else if (bus.beat_cnt_en) m_el = bf ? 0 : (m_el + 1) % (8 * BT);
    if (!bus.addr_rstn) begin
      m_addr = int'(bus.sel) * (1 << (ADDR_W - 2));
    end else if (bus.addr_en && (rd % 8) != 0) begin
      m_note = rd / 8;
      m_beat = rd % 8;
      m_addr = (m_addr + 1) % (1 << ADDR_W);
    end
  endtask

  // One clock: inputs already driven; push expectation, observe finishes, advance model
  task automatic step();
    exp_t e;
    #1;
    e.addr = 8'(m_addr);
    e.buz  = m_buz;
    e.af   = bus.addr_en && (rom[m_addr][2:0] == 3'd0);
    e.bf   = m_bf();
    exp_q.push_back(e);
    obs_af = bus.addr_finish;
    obs_bf = bus.beat_finish;
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rom_addr", 32'(bus.rom_addr), 32'(mon_e.addr));
      check("buzzer", 32'(buzzer), 32'(mon_e.buz));
      check("addr_finish", 32'(bus.addr_finish), 32'(mon_e.af));
      check("beat_finish", 32'(bus.beat_finish), 32'(mon_e.bf));
    end
  end

  task automatic idle_inputs();
    bus.addr_en = 1'b0; bus.addr_rstn = 1'b1;
    bus.tune_pwm_en = 1'b0; bus.tune_pwm_rstn = 1'b1;
    bus.beat_cnt_en = 1'b0; bus.beat_cnt_rstn = 1'b1;
  endtask

  initial begin
    int t1, t2, nbf, first_bf, prev;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h80] = 8'b00110_010;
    rom[8'h81] = {5'd6, 3'd3};
    rom[8'h82] = {5'd9, 3'd0};
    rom[8'h40] = {5'd0, 3'd1};
    rom[8'h41] = {5'd21, 3'd1};
    rstn = 1'b0;
    bus.sel = 2'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
    check("reset_buzzer", 32'(buzzer), 32'h0);
    rstn = 1'b1;
    repeat (3) step();

    // Fetch from song 2
    bus.sel = 2'd2; bus.addr_rstn = 1'b0; step();
    check("fetch_base", 32'(bus.rom_addr), 32'h80);
    bus.addr_rstn = 1'b1; bus.addr_en = 1'b1; step();
    check("fetch_af", 32'(obs_af), 32'h0);
    bus.addr_en = 1'b0;
    check("fetch_next", 32'(bus.rom_addr), 32'h81);

    // A4 tone: half-period 227 clocks at this clock rate
    bus.tune_pwm_rstn = 1'b0; step();
    bus.tune_pwm_rstn = 1'b1; bus.tune_pwm_en = 1'b1;
    t1 = 0; t2 = 0; prev = 0;
    for (int k = 1; k <= 500; k++) begin
      step();
      if (int'(buzzer) != prev) begin
        if (t1 == 0) t1 = k; else if (t2 == 0) t2 = k;
        prev = int'(buzzer);
      end
    end
    check("tone_first_toggle", 32'(t1), 32'd227);
    check("tone_half_period", 32'(t2 - t1), 32'd227);

    // Three-beat note: one finish pulse on enabled cycle 30
    bus.addr_en = 1'b1; step();
    bus.addr_en = 1'b0;
    bus.beat_cnt_rstn = 1'b0; step();
    bus.beat_cnt_rstn = 1'b1; bus.beat_cnt_en = 1'b1;
    nbf = 0; first_bf = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (obs_bf) begin
        nbf++;
        if (first_bf == 0) first_bf = k;
      end
    end
    check("beat_first_pulse", 32'(first_bf), 32'd30);
    check("beat_pulse_count", 32'(nbf), 32'd1);
    bus.beat_cnt_en = 1'b0;

    // End-of-song marker
    bus.addr_en = 1'b1; step();
    check("eos_af", 32'(obs_af), 32'h1);
    bus.addr_en = 1'b0;
    check("eos_addr_hold", 32'(bus.rom_addr), 32'h82);

    // Rest note keeps the buzzer low
    bus.sel = 2'd1; bus.addr_rstn = 1'b0; step();
    bus.addr_rstn = 1'b1; bus.addr_en = 1'b1; step();
    bus.addr_en = 1'b0;
    repeat (100) step();
    check("rest_buzzer", 32'(buzzer), 32'h0);

    // One-beat B6 note with the buzzer high entering the last beat
    bus.addr_en = 1'b1; step();
    bus.addr_en = 1'b0;
    bus.tune_pwm_rstn = 1'b0; bus.beat_cnt_rstn = 1'b0; step();
    bus.tune_pwm_rstn = 1'b1; bus.beat_cnt_rstn = 1'b1;
    repeat (60) step();
    check("stacc_pre_high", 32'(buzzer), 32'h1);
    bus.beat_cnt_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 7) check("stacc_c7", 32'(buzzer), 32'h1);
      if (k >= 8) check("stacc_gap", 32'(buzzer), STACC ? 32'h0 : 32'h1);
      if (k == 10) check("stacc_bf", 32'(obs_bf), 32'h1);
    end

    // Reset mid-tone
    repeat (5) step();
    rstn = 1'b0; idle_inputs();
    repeat (2) step();
    check("midreset_addr", 32'(bus.rom_addr), 32'h0);
    check("midreset_buzzer", 32'(buzzer), 32'h0);
    rstn = 1'b1;
    repeat (3) step();

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rstn              = ($urandom_range(0, 199) != 0);
      bus.sel           = 2'($urandom_range(0, 3));
      bus.addr_rstn     = ($urandom_range(0, 19) != 0);
      bus.addr_en       = ($urandom_range(0, 9) == 0);
      bus.tune_pwm_rstn = ($urandom_range(0, 199) != 0);
      bus.tune_pwm_en   = ($urandom_range(0, 9) != 0);
      bus.beat_cnt_rstn = ($urandom_range(0, 49) != 0);
      bus.beat_cnt_en   = ($urandom_range(0, 9) != 0);
      step();
    end

    idle_inputs();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
